// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : RV32I instruction-fetch stage. Owns the PC, addresses the
//             combinational instruction ROM and fills the IF/ID register.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] ROM_BASE = 32'hBFC00000,
    parameter logic [31:0] ROM_TOP  = 32'hBFC00FFC,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] rom_addr_o,
    input  logic [WIDTH-1:0] rom_data_i,
    output logic [WIDTH-1:0] instr_d_o,
    output logic [WIDTH-1:0] pc_d_o,
    output logic [WIDTH-1:0] pc_plus4_d_o,
    output logic             valid_d_o,
    output logic             fault_o
);

    localparam logic [WIDTH-1:0] c_BASE = WIDTH'(ROM_BASE);
    localparam logic [WIDTH-1:0] c_TOP  = WIDTH'(ROM_TOP);
    localparam logic [WIDTH-1:0] c_NOP  = WIDTH'(NOP);
    localparam logic [WIDTH-1:0] c_FOUR = WIDTH'(4);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr_d;
    logic [WIDTH-1:0] r_pc_d;
    logic [WIDTH-1:0] r_pc_plus4_d;
    logic             r_valid_d;
    logic             r_fault;

    logic [WIDTH-1:0] w_pc_plus4;
    logic             w_target_legal;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_instr_next;
    logic [WIDTH-1:0] w_pc_d_next;
    logic [WIDTH-1:0] w_pc_plus4_d_next;
    logic             w_valid_next;
    logic             w_fault_next;

    assign w_pc_plus4     = r_pc + c_FOUR;
    assign w_target_legal = (target_i >= c_BASE) && (target_i <= c_TOP) &&
                            (target_i[1:0] == 2'b00);

    // Redirect outranks stall: the fetched word is squashed into a bubble.
    always_comb begin
        w_pc_next         = r_pc;
        w_instr_next      = r_instr_d;
        w_pc_d_next       = r_pc_d;
        w_pc_plus4_d_next = r_pc_plus4_d;
        w_valid_next      = r_valid_d;
        w_fault_next      = r_fault;
        if (redirect_i) begin
            w_instr_next      = c_NOP;
            w_pc_d_next       = c_ZERO;
            w_pc_plus4_d_next = c_ZERO;
            w_valid_next      = 1'b0;
            if (w_target_legal) begin
                w_pc_next = target_i;
            end else begin
                w_pc_next    = c_BASE;
                w_fault_next = 1'b1;
            end
        end else if (!stall_i) begin
            w_instr_next      = rom_data_i;
            w_pc_d_next       = r_pc;
            w_pc_plus4_d_next = w_pc_plus4;
            w_valid_next      = 1'b1;
            w_pc_next         = (r_pc == c_TOP) ? c_BASE : w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= c_BASE;
            r_instr_d    <= c_NOP;
            r_pc_d       <= c_ZERO;
            r_pc_plus4_d <= c_ZERO;
            r_valid_d    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_instr_d    <= w_instr_next;
            r_pc_d       <= w_pc_d_next;
            r_pc_plus4_d <= w_pc_plus4_d_next;
            r_valid_d    <= w_valid_next;
            r_fault      <= w_fault_next;
        end
    end

    assign rom_addr_o   = r_pc;
    assign instr_d_o    = r_instr_d;
    assign pc_d_o       = r_pc_d;
    assign pc_plus4_d_o = r_pc_plus4_d;
    assign valid_d_o    = r_valid_d;
    assign fault_o      = r_fault;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RV32I core. It owns the program counter and drives the byte address into the combinational instruction ROM, which maps 0xBFC00000–0xBFC00FFF. It registers the returned 32-bit instruction, its PC and PC+4 into the IF/ID pipeline register for decode. It also handles stalls, control-flow redirects, ROM-window wrap and out-of-window redirect faults.

Parameters:
WIDTH, 32, address/data width
ROM_BASE, 32'hBFC00000, reset PC and lowest ROM byte address
ROM_TOP, 32'hBFC00FFC, highest legal word-aligned fetch address
NOP, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall_i  in  1  hold PC and IF/ID (load-use hazard from ID)
redirect_i  in  1  taken branch/jump resolved downstream
target_i  in  WIDTH  redirect byte address
rom_addr_o  out  WIDTH  byte address to ROM (= current PC)
rom_data_i  in  WIDTH  instruction returned combinationally by ROM
instr_d_o  out  WIDTH  IF/ID instruction
pc_d_o  out  WIDTH  IF/ID PC
pc_plus4_d_o  out  WIDTH  IF/ID PC+4
valid_d_o  out  1  IF/ID holds a real instruction
fault_o  out  1  sticky: redirect target outside ROM window or misaligned

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: pc=ROM_BASE, so rom_addr_o=ROM_BASE; instr_d_o=NOP; pc_d_o=0; pc_plus4_d_o=0; valid_d_o=0; fault_o=0.
- rom_addr_o = pc, combinationally. The ROM is combinational, so rom_data_i is valid in the same cycle.
- Latency: the instruction at pc in cycle n appears on instr_d_o in cycle n+1, with pc_d_o=pc and valid_d_o=1.
- Priority per edge: rst > redirect_i > stall_i > normal advance.
- Normal advance (no rst, redirect_i=0, stall_i=0):
  - IF/ID <= {rom_data_i, pc, pc+4, valid=1}.
  - pc <= pc+4; if pc==ROM_TOP, pc <= ROM_BASE (wrap, no fault).
- Stall (stall_i=1, redirect_i=0): pc and all IF/ID outputs hold their values. rom_addr_o is unchanged.
- Redirect (redirect_i=1, regardless of stall_i):
  - IF/ID <= bubble {NOP, pc_d=0, pc_plus4_d=0, valid=0}. The instruction fetched this cycle is discarded.
  - Legal target (ROM_BASE <= target_i <= ROM_TOP and target_i[1:0]==0): pc <= target_i.
  - Otherwise: pc <= ROM_BASE and fault_o <= 1.
- fault_o is sticky and clears only on rst.
- Back-to-back redirects: each one is applied, and every redirect cycle produces a bubble.
- Reset asserted mid-stall or mid-redirect: reset wins. State is the reset state on the next edge.
- pc+4 arithmetic is modulo 2^WIDTH. pc_plus4_d_o is registered, not recomputed downstream.
- No combinational path from stall_i, redirect_i or target_i to any output except through registers.

Test Plan:
- Reset then free-run 3 cycles, ROM words W0..W2 at 0xBFC00000/04/08 → rom_addr_o steps BFC00000, BFC00004, BFC00008. instr_d_o is NOP/valid=0 in the first cycle after reset, then W0 with pc_d_o=BFC00000 and pc_plus4_d_o=BFC00004, then W1.
- Stall held 2 cycles at pc=BFC00008 → rom_addr_o stays BFC00008 and IF/ID stays W1/BFC00004 for both cycles. On release, IF/ID=W2 with pc_d_o=BFC00008.
- Redirect to BFC00100 at pc=BFC0000C → next cycle rom_addr_o=BFC00100 and valid_d_o=0, instr_d_o=00000013. The following cycle pc_d_o=BFC00100 and valid_d_o=1.
- Redirect and stall together, target BFC00040 → redirect wins: pc=BFC00040 and a bubble is inserted.
- Free-run from pc=BFC00FFC → next rom_addr_o=BFC00000 with fault_o=0. Then redirect to C0000000 → rom_addr_o=BFC00000 and fault_o=1. Then redirect to BFC00002 → fault_o stays 1. After rst, fault_o=0.
- Assert rst during a stall with pc=BFC00020 → next edge rom_addr_o=BFC00000, valid_d_o=0, instr_d_o=NOP.
